corner_tracker: RTL

- Parametrised, multi-channel successor to the single-mask corner finder in the camera-to-VGA pipeline.
- Consumes a raster stream of NUM_CH binary mask bits per pixel, with explicit start-of-frame framing and valid qualification.
- Tracks four extreme corners per channel and saturating pixel counts.
- At end of frame, publishes a double-buffered, frame-consistent result set with a one-cycle done pulse, per-channel success flags and a framing-error flag.

---
 rtl/corner_tracker_if.sv | 30 +++
 rtl/corner_tracker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/corner_tracker_if.sv
// Pixel-in / corner-result-out bundle for corner_tracker.
// Field names keep the block's historical i_/o_ naming.
interface corner_tracker_if #(
  parameter int NUM_CH = 2,
  parameter int AW     = 20
);
  logic                   i_sof;
  logic                   i_valid;
  logic [NUM_CH-1:0]      i_data;
  logic                   o_valid;
  logic [NUM_CH-1:0]      o_success;
  logic                   o_frame_err;
  logic                   o_busy;
  logic [NUM_CH*AW-1:0]   o_ul_addr;
  logic [NUM_CH*AW-1:0]   o_ur_addr;
  logic [NUM_CH*AW-1:0]   o_dl_addr;
  logic [NUM_CH*AW-1:0]   o_dr_addr;

  modport master (
    output i_sof, i_valid, i_data,
    input  o_valid, o_success, o_frame_err, o_busy,
    input  o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr
  );

  modport slave (
    input  i_sof, i_valid, i_data,
    output o_valid, o_success, o_frame_err, o_busy,
    output o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr
  );
endinterface

// File: rtl/corner_tracker.sv
// Multi-channel extreme-corner tracker over a raster mask stream, with a
// double-buffered result bank published once per complete frame.
module corner_lane #(
  parameter int H_RES = 800,
  parameter int V_RES = 600,
  parameter int RW    = 10,
  parameter int CW    = 10,
  parameter int CNT_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hit,
  input  logic                upd,
  input  logic                restart,
  input  logic                clear,
  input  logic [RW-1:0]       r,
  input  logic [CW-1:0]       c,
  output logic [RW+CW-1:0]    ul_n,
  output logic [RW+CW-1:0]    ur_n,
  output logic [RW+CW-1:0]    dl_n,
  output logic [RW+CW-1:0]    dr_n,
  output logic [CNT_W-1:0]    cnt_n
);
  localparam int AW = RW + CW;
  localparam logic [AW-1:0] UL_S = {RW'(V_RES-1), CW'(H_RES-1)};
  localparam logic [AW-1:0] UR_S = {RW'(V_RES-1), CW'(0)};
  localparam logic [AW-1:0] DL_S = {RW'(0), CW'(H_RES-1)};
  localparam logic [AW-1:0] DR_S = '0;

  logic [AW-1:0]    ul, ur, dl, dr;
  logic [CNT_W-1:0] cnt;

  // A restarting pixel compares against sentinels, never the aborted frame.
  always_comb begin
    ul_n  = restart ? UL_S : ul;
    ur_n  = restart ? UR_S : ur;
    dl_n  = restart ? DL_S : dl;
    dr_n  = restart ? DR_S : dr;
    cnt_n = restart ? '0 : cnt;
    if (upd && hit) begin
      if (r <  ul_n[AW-1 -: RW]) ul_n = {r, c};
      if (c >  ur_n[CW-1:0])     ur_n = {r, c};
      if (c <= dl_n[CW-1:0])     dl_n = {r, c};
      if (r >= dr_n[AW-1 -: RW]) dr_n = {r, c};
      if (cnt_n != '1)           cnt_n = cnt_n + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ul <= UL_S; ur <= UR_S; dl <= DL_S; dr <= DR_S; cnt <= '0;
    end else if (clear) begin
      ul <= UL_S; ur <= UR_S; dl <= DL_S; dr <= DR_S; cnt <= '0;
    end else if (upd) begin
      ul <= ul_n; ur <= ur_n; dl <= dl_n; dr <= dr_n; cnt <= cnt_n;
    end
  end
endmodule

module corner_tracker #(
  parameter int H_RES   = 800,
  parameter int V_RES   = 600,
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 12,
  parameter int MIN_PIX = 255
) (
  input  logic           i_clk,
  input  logic           i_rst,
  corner_tracker_if.slave bus
);
  localparam int RW = $clog2(V_RES);
  localparam int CW = $clog2(H_RES);
  localparam int AW = RW + CW;

  typedef enum logic {WAIT_SOF, SCAN} state_t;
  state_t state, state_n;

  logic [RW-1:0] row, r_eff;
  logic [CW-1:0] col, c_eff;
  logic          restart, upd, last;

  logic [NUM_CH-1:0][AW-1:0]    ul_n, ur_n, dl_n, dr_n;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_n;
  logic [NUM_CH-1:0]            succ_n;

  assign restart = bus.i_valid && bus.i_sof;
  assign upd     = bus.i_valid && (state == SCAN || bus.i_sof);
  assign r_eff   = restart ? '0 : row;
  assign c_eff   = restart ? '0 : col;
  // A sof on the final position is an early sof, so it never publishes.
  assign last    = upd && !bus.i_sof &&
                   row == RW'(V_RES-1) && col == CW'(H_RES-1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= WAIT_SOF;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    bus.o_busy = 1'b0;
    case (state)
      WAIT_SOF: if (restart) state_n = SCAN;
      SCAN: begin
        bus.o_busy = 1'b1;
        if (last) state_n = WAIT_SOF;
      end
      default: state_n = WAIT_SOF;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row <= '0;
      col <= '0;
    end else if (last) begin
      row <= '0;
      col <= '0;
    end else if (upd) begin
      if (c_eff == CW'(H_RES-1)) begin
        row <= r_eff + RW'(1);
        col <= '0;
      end else begin
        row <= r_eff;
        col <= c_eff + CW'(1);
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_lane
      corner_lane #(
        .H_RES(H_RES), .V_RES(V_RES), .RW(RW), .CW(CW), .CNT_W(CNT_W)
      ) u_lane (
        .clk(i_clk), .rst(i_rst), .hit(bus.i_data[k]), .upd(upd),
        .restart(restart), .clear(last), .r(r_eff), .c(c_eff),
        .ul_n(ul_n[k]), .ur_n(ur_n[k]), .dl_n(dl_n[k]), .dr_n(dr_n[k]),
        .cnt_n(cnt_n[k])
      );
      assign succ_n[k] = (cnt_n[k] >= CNT_W'(MIN_PIX));
    end
  endgenerate

  // Output bank takes the lanes' next values so the last pixel is included.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid     <= 1'b0;
      bus.o_success   <= '0;
      bus.o_frame_err <= 1'b0;
      bus.o_ul_addr   <= '0;
      bus.o_ur_addr   <= '0;
      bus.o_dl_addr   <= '0;
      bus.o_dr_addr   <= '0;
    end else begin
      bus.o_valid <= last;
      if (last) begin
        bus.o_success   <= succ_n;
        bus.o_frame_err <= 1'b0;
        bus.o_ul_addr   <= ul_n;
        bus.o_ur_addr   <= ur_n;
        bus.o_dl_addr   <= dl_n;
        bus.o_dr_addr   <= dr_n;
      end else if (restart && state == SCAN) begin
        bus.o_frame_err <= 1'b1;
      end
    end
  end
endmodule
